// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register-burst controller.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    WRITE,
    FIN
  } state_t;

  localparam int TMO_DEFAULT = 1023;

endpackage

// File: rtl/spi_timeout.sv
// Saturating watchdog: cleared before each SPI byte, counts enabled cycles,
// flags expiry once the count has reached TMO.
module spi_timeout
  import spi_ctrl_pkg::*;
#(
  parameter int TMO = TMO_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TMO);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != LIMIT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = (cnt_reg == LIMIT);

endmodule

// File: rtl/ctrl_spi_regs.sv
// Burst controller: reads register-file entries 0..end_idx, sends the low byte
// of each over SPI and writes the received byte back to the same entry.
module ctrl_spi_regs
  import spi_ctrl_pkg::*;
#(
  parameter int N   = 5,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         send,
  input  logic         all_regs,
  input  logic [N:0]   last,
  input  logic [31:0]  rd_data,
  output logic         hold_ctrl,
  output logic [N:0]   addr2,
  output logic         wr2,
  output logic [7:0]   in2,
  output logic         spi_start,
  output logic [7:0]   spi_tx,
  input  logic         spi_done,
  input  logic [7:0]   spi_rx,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N+1:0] count
);

  state_t       state_reg, state_next;
  logic [N:0]   idx_reg;
  logic [N:0]   end_idx_reg;
  logic [N+1:0] count_reg;
  logic         err_reg;
  logic [7:0]   tx_reg;
  logic [7:0]   rx_reg;

  logic wd_clear;
  logic wd_enable;
  logic wd_expire;

  // Only the low byte of each register is transmitted.
  logic unused_rd_bits;
  assign unused_rd_bits = ^rd_data[31:8];

  spi_timeout #(
    .TMO(TMO)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (wd_clear),
    .enable(wd_enable),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg     <= '0;
      end_idx_reg <= '0;
      count_reg   <= '0;
      err_reg     <= 1'b0;
      tx_reg      <= '0;
      rx_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (send) begin
            end_idx_reg <= all_regs ? last : '0;
            idx_reg     <= '0;
            count_reg   <= '0;
            err_reg     <= 1'b0;
          end
        end
        LOAD: tx_reg <= rd_data[7:0];
        WAIT: begin
          // A completion arriving on the expiry cycle still counts as success.
          if (spi_done) begin
            rx_reg <= spi_rx;
          end else if (wd_expire) begin
            err_reg <= 1'b1;
          end
        end
        WRITE: begin
          count_reg <= count_reg + 1'b1;
          if (idx_reg != end_idx_reg) begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_ctrl  = 1'b0;
    addr2      = '0;
    wr2        = 1'b0;
    spi_start  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (send) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        hold_ctrl  = 1'b1;
        addr2      = idx_reg;
        state_next = START;
      end
      START: begin
        hold_ctrl  = 1'b1;
        addr2      = idx_reg;
        spi_start  = 1'b1;
        wd_clear   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        hold_ctrl = 1'b1;
        addr2     = idx_reg;
        if (spi_done) begin
          state_next = WRITE;
        end else if (wd_expire) begin
          state_next = FIN;
        end else begin
          wd_enable = 1'b1;
        end
      end
      WRITE: begin
        hold_ctrl  = 1'b1;
        addr2      = idx_reg;
        wr2        = 1'b1;
        state_next = (idx_reg == end_idx_reg) ? FIN : LOAD;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in2    = rx_reg;
  assign spi_tx = tx_reg;
  assign err    = err_reg;
  assign count  = count_reg;

endmodule

// File: doc/ctrl_spi_regs.md
CTRL_SPI_REGS -- requirements
Module: ctrl_spi_regs

Interface
REQ-001 The block SHALL have parameter N, default 5: register-file address is N+1 bits (entries 0..2^(N+1)-1).
REQ-002 The block SHALL have parameter TMO, default 1023: maximum cycles spent in WAIT before abort.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 send  in  1  start-burst request, sampled in IDLE only.
REQ-006 all_regs  in  1  1: transfer entries 0..last; 0: entry 0 only.
REQ-007 last  in  N+1  highest entry index of a burst, sampled with send.
REQ-008 rd_data  in  32  register-file read data for addr2 (combinational).
REQ-009 hold_ctrl  out  1  1 while the controller owns the register-file port.
REQ-010 addr2  out  N+1  register-file address driven by the controller.
REQ-011 wr2  out  1  register-file write strobe, one cycle per entry.
REQ-012 in2  out  8  received byte written back.
REQ-013 spi_start  out  1  one-cycle pulse launching one SPI byte transfer.
REQ-014 spi_tx  out  8  byte to transmit, stable from START until WRITE.
REQ-015 spi_done  in  1  one-cycle pulse from SPI engine: transfer complete.
REQ-016 spi_rx  in  8  received byte, valid when spi_done=1.
REQ-017 busy  out  1  1 in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at burst end.
REQ-019 err  out  1  sticky timeout flag, cleared by next accepted send.
REQ-020 count  out  N+2  number of entries completed in current/last burst.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, START, WAIT, WRITE, FIN.
REQ-022 IDLE: send=1 SHALL latch end_idx = all_regs ? last : 0, clear idx, count, err, and go LOAD next cycle.
REQ-023 LOAD: hold_ctrl=1, addr2=idx; tx_byte SHALL capture rd_data[7:0]; next START.
REQ-024 START: spi_start=1 for exactly one cycle; next WAIT; watchdog cleared.
REQ-025 WAIT: spi_done=1 SHALL capture spi_rx into rx_byte and go WRITE; watchdog increments each cycle otherwise.
REQ-026 WAIT: watchdog reaching TMO without spi_done SHALL set err and go FIN with no write for that entry.
REQ-027 WRITE: wr2=1, in2=rx_byte, addr2=idx for one cycle; count increments; next FIN if idx==end_idx else idx+1 and LOAD.
REQ-028 FIN: done=1 one cycle, hold_ctrl=0; next IDLE.
REQ-029 Per-entry latency SHALL be 3 cycles plus SPI time (LOAD, START, WAIT≥1, WRITE); a send-to-done single-entry burst with spi_done on first WAIT cycle takes 5 cycles.
REQ-030 hold_ctrl SHALL be 1 in LOAD, START, WAIT, WRITE; 0 in IDLE and FIN.
REQ-031 send while busy SHALL be ignored; spi_done outside WAIT SHALL be ignored.
REQ-032 spi_done coinciding with watchdog==TMO SHALL count as success (done wins).
REQ-033 last=2^(N+1)-1 SHALL transfer all entries; idx SHALL not wrap past end_idx.
REQ-034 wr2 SHALL never assert when hold_ctrl=0.

Reset
REQ-035 rst=1 at any time, including mid-burst, SHALL force IDLE and drive hold_ctrl, wr2, spi_start, busy, done, err to 0, addr2, in2, spi_tx, count to 0; the burst is abandoned.
REQ-036 After rst deasserts the first accepted send SHALL behave as from power-up.

Structure
REQ-037 The state enum and default TMO constant SHALL live in shared package spi_ctrl_pkg.
REQ-038 The watchdog SHALL be sub-module spi_timeout (clear, enable, expire); all else in ctrl_spi_regs.

Verification
REQ-039 Single entry: all_regs=0, rd_data[7:0]=0xA5, spi_done with spi_rx=0x3C after 8 cycles -> spi_tx=0xA5, wr2 once at addr2=0 in2=0x3C, done, count=1, err=0.
REQ-040 Burst: all_regs=1, last=3 -> four spi_start pulses, wr2 at addr2 0,1,2,3 in order, count=4, one done.
REQ-041 Timeout: no spi_done -> err=1 after TMO WAIT cycles, no wr2, done pulse, count=0.
REQ-042 Reset mid-burst at entry 2 of 0..5 -> all outputs 0 next cycle, IDLE; new send runs normally from entry 0.
REQ-043 send pulses during busy and spurious spi_done in LOAD -> ignored; burst results unchanged.
REQ-044 spi_done on exact TMO cycle -> write occurs, err=0.
